// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a small FIFO, configurable framing.
module uart_tx_fifo #(
  parameter int CLK_DIV    = 434,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 tx,
  output logic                 busy,
  output logic                 full,
  output logic                 overrun
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY_BIT, STOP} state_t;
  state_t state, state_n;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [15:0] baud;
  logic [3:0] bit_cnt;
  logic [DATA_BITS-1:0] sh;
  logic par, tx_n, pop, push, baud_end, last;
  assign push = start && !full;
  assign full = count == (AW+1)'(FIFO_DEPTH);
  assign busy = state != IDLE || count != 0;
  assign baud_end = baud == 16'(CLK_DIV - 1);
  assign last = bit_cnt == 4'(state == DATA ? DATA_BITS - 1 : STOP_BITS - 1);
  always_comb begin
    state_n = state;
    pop = 1'b0;
    tx_n = tx;
    case (state)
      IDLE: if (count != 0) begin
        pop = 1'b1;
        state_n = START;
        tx_n = 1'b0;
      end
      START: if (baud_end) begin
        state_n = DATA;
        tx_n = sh[0];
      end
      DATA: if (baud_end) begin
        state_n = !last ? DATA : PARITY != 0 ? PARITY_BIT : STOP;
        tx_n = !last ? sh[0] : PARITY != 0 ? par : 1'b1;
      end
      PARITY_BIT: if (baud_end) begin
        state_n = STOP;
        tx_n = 1'b1;
      end
      STOP: if (baud_end && last) begin
        pop = count != 0;
        state_n = count != 0 ? START : IDLE;
        tx_n = count == 0;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (push && !rst) mem[wr_ptr] <= data_in;
  // Shifter and parity are captured at pop so the FIFO slot can be reused at once.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      tx <= 1'b1;
      baud <= '0;
      bit_cnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overrun <= 1'b0;
      sh <= '0;
      par <= 1'b0;
    end else begin
      state <= state_n;
      tx <= tx_n;
      baud <= (state == IDLE || baud_end) ? '0 : baud + 1'b1;
      bit_cnt <= state_n != state ? '0 : baud_end ? bit_cnt + 1'b1 : bit_cnt;
      wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      overrun <= overrun | (start & full);
      sh <= pop ? mem[rd_ptr] : (baud_end && (state == START || state == DATA)) ? sh >> 1 : sh;
      par <= pop ? ^mem[rd_ptr] ^ (PARITY == 1) : par;
    end
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter CLK_DIV, default 434, clock cycles per bit period (range 2..65535).
REQ-002 Parameter DATA_BITS, default 8, payload bits per frame (range 5..9).
REQ-003 Parameter PARITY, default 0: 0 = none, 1 = odd, 2 = even.
REQ-004 Parameter STOP_BITS, default 1, stop bits per frame (1 or 2).
REQ-005 Parameter FIFO_DEPTH, default 4, transmit queue entries (power of 2, range 2..64).
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 start  input  1  write strobe; queues data_in when asserted.
REQ-009 data_in  input  DATA_BITS  word to transmit.
REQ-010 tx  output  1  serial line, idle high, registered.
REQ-011 busy  output  1  high while a frame is on the line or the FIFO is non-empty.
REQ-012 full  output  1  FIFO holds FIFO_DEPTH words.
REQ-013 overrun  output  1  sticky flag: a write was attempted while full.

Function
REQ-014 A start sampled high with full low SHALL write data_in into the FIFO at that edge.
REQ-015 A start sampled high with full high SHALL drop the word and set overrun; overrun holds until rst.
REQ-016 The FSM SHALL use these states: IDLE, START, DATA, PARITY, STOP.
REQ-017 In IDLE with the FIFO non-empty, the block SHALL, at the next edge, pop one word, drive tx = 0, and enter START.
REQ-018 A word written at edge N into an empty FIFO while in IDLE SHALL cause tx to fall at edge N+1.
REQ-019 Each bit SHALL be held for exactly CLK_DIV cycles, timed by a baud counter that restarts at every bit boundary.
REQ-020 In DATA, the block SHALL shift out DATA_BITS bits, LSB first.
REQ-021 With PARITY = 0, the block SHALL skip the PARITY state.
REQ-022 Otherwise, the parity bit SHALL make the total count of ones in data plus parity odd (PARITY = 1) or even (PARITY = 2).
REQ-023 In STOP, tx SHALL be 1 for STOP_BITS*CLK_DIV cycles.
REQ-024 Frame length SHALL be CLK_DIV*(1 + DATA_BITS + (PARITY != 0) + STOP_BITS) cycles.
REQ-025 At the end of STOP with the FIFO non-empty, the next start bit SHALL begin on the following edge with no idle gap; otherwise the FSM returns to IDLE with tx = 1.
REQ-026 A simultaneous write and pop SHALL be legal when not full, leaving the occupancy unchanged.
REQ-027 A write while full SHALL be rejected even if a pop occurs on the same edge.
REQ-028 The FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy uses a log2(FIFO_DEPTH)+1-bit counter.
REQ-029 The shift register SHALL be loaded at pop time, so data_in may change freely after its write.
REQ-030 busy SHALL fall on the same edge at which the FSM re-enters IDLE with the FIFO empty.

Reset
REQ-031 rst high SHALL, asynchronously, drive tx = 1, busy = 0, full = 0, and overrun = 0.
REQ-032 rst high SHALL empty the FIFO, clear all counters, and force the FSM to IDLE.
REQ-033 rst asserted mid-frame SHALL abort the frame immediately with tx = 1; no partial frame resumes after release.
REQ-034 Writes SHALL be ignored while rst is high.

Verification
REQ-035 The bench SHALL cover these directed scenarios, using CLK_DIV=4, DATA_BITS=8, PARITY=2, STOP_BITS=1, FIFO_DEPTH=4:
- Single write of 0x1A at edge N -> tx = 0 for edges N+1..N+4; data bits 0,1,0,1,1,0,0,0 at 4 cycles each; parity 1; stop 1; busy low at edge N+45.
- Three back-to-back writes 0x00, 0xFF, 0x55 -> three contiguous 44-cycle frames, no idle cycles between them; parity bits 0, 0, 0.
- Six writes on consecutive cycles -> full rises after the 4th queued word; 6th write dropped and overrun = 1; exactly 5 frames sent (one popped before the 6th write).
- rst pulsed for 1 cycle during the 3rd data bit -> tx = 1 at once, FIFO empty, busy = 0, no further frames.
- PARITY=1, STOP_BITS=2, DATA_BITS=7, write 0x7F -> frame of 7 ones, parity 0, stop high for 8 cycles, 44 cycles total.
- Write and pop on the same edge with 1 word queued -> occupancy stays 1, both words transmitted in order.
